// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types for the FIFO drain path.
package fifo_pkg;
   localparam int DATA_W = 16;
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } buf_entry_t;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} buf_state_t;
endpackage

// File: rtl/fifo_stream_drain_skid_buf2.sv
// skid_buf2: two-entry valid/ready buffer; head is always a registered entry.
module skid_buf2
   import fifo_pkg::*;
#(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [1:0]   occ,
   output logic [W-1:0] head
);
   buf_state_t   state_q, state_d;
   logic         hd_q, hd_d;
   logic         tail;
   logic [W-1:0] ent_q [2];
   logic [W-1:0] ent_d [2];
   always_comb begin
      tail = hd_q ^ (state_q == ONE);
      ent_d = ent_q;
      if (push) ent_d[tail] = push_data;
      hd_d = pop ? ~hd_q : hd_q;
      state_d = buf_state_t'(2'(state_q) + 2'(push) - 2'(pop));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         hd_q <= 1'b0;
         ent_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         hd_q <= hd_d;
         ent_q <= ent_d;
      end
   end
   assign occ = state_q;
   assign head = ent_q[hd_q];
   assert property (@(posedge clk) disable iff (!rst_n) !(push && state_q == FULL));
   assert property (@(posedge clk) disable iff (!rst_n) !(pop && state_q == EMPTY));
endmodule

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: issues FIFO reads, absorbs read latency in a skid buffer,
// and presents a valid/ready stream tagged with burst-boundary last.
module fifo_stream_drain
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = 16,
   parameter int BURST_LEN  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  fifo_rd_en,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  err
);
   localparam int CW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(BURST_LEN - 1);
   logic            inflight_q, inflight_d;
   logic            err_q, err_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      occ, room;
   logic            pop;
   logic [FIFO_WIDTH:0] head;
   // Counting a same-cycle pop as free space keeps full throughput; this makes m_ready -> fifo_rd_en combinational.
   always_comb begin
      pop = m_valid && m_ready;
      room = occ + 2'(inflight_q) - 2'(pop);
      fifo_rd_en = !fifo_empty && room < 2'd2;
      inflight_d = fifo_rd_en;
      cnt_d = !inflight_q ? cnt_q : cnt_q == CNT_MAX ? '0 : cnt_q + 1'b1;
      err_d = err_q || fifo_underflow;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
   skid_buf2 #(.W(FIFO_WIDTH + 1)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data ({fifo_data_out, cnt_q == CNT_MAX}),
      .pop       (pop),
      .occ       (occ),
      .head      (head)
   );
   assign m_valid = occ != 2'd0;
   assign {m_data, m_last} = head;
   assign err = err_q;
   assert property (@(posedge clk) disable iff (!rst_n) 3'(occ) + 3'(inflight_q) <= 3'd2);
   assert property (@(posedge clk) disable iff (!rst_n) !(fifo_rd_en && fifo_empty));
   assert property (@(posedge clk) disable iff (!rst_n)
      m_valid && !m_ready |=> m_valid && $stable(m_data) && $stable(m_last));
   assert property (@(posedge clk) disable iff (!rst_n) !$rose(err_q))
      else $info("err set: FIFO reported underflow");
endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb_fifo_stream_drain: directed vectors plus hand-written corner sequences,
// with a behavioural FIFO in front and a scoreboard on the stream side.
module tb_fifo_stream_drain;
   localparam int BL = 8;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fifo_rd_en, fifo_empty, fifo_underflow;
   logic [15:0] fifo_data_out;
   logic        m_valid, m_last, err;
   logic        m_ready = 1'b0;
   logic [15:0] m_data;
   logic        wr_en = 1'b0, uf_force = 1'b0, uf_model;
   logic [15:0] wr_data = '0, fdo;
   logic [15:0] fq[$];
   logic [15:0] exp_q[$];
   int fcnt = 0;
   int n_cmp = 0, n_fail = 0, cyc = 0, rd_cnt = 0;
   int beats = 0, lasts = 0, bidx = 0, first_cyc = 0, last_cyc = 0;
   logic        stall_prev = 1'b0, prev_last;
   logic [15:0] prev_data;

   typedef struct {
      int          n;
      logic [15:0] base;
      int          mode;
      int          exp_lasts;
   } vec_t;
   vec_t vecs[4];

   fifo_stream_drain #(.FIFO_WIDTH(16), .BURST_LEN(BL)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fifo_rd_en     (fifo_rd_en),
      .fifo_data_out  (fifo_data_out),
      .fifo_empty     (fifo_empty),
      .fifo_underflow (fifo_underflow),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_data         (m_data),
      .m_last         (m_last),
      .err            (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign fifo_empty = fcnt == 0;
   assign fifo_data_out = fdo;
   assign fifo_underflow = uf_force | uf_model;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fq.delete();
         fcnt <= 0;
         fdo <= '0;
         uf_model <= 1'b0;
      end else begin
         uf_model <= fifo_rd_en && fq.size() == 0;
         if (fifo_rd_en && fq.size() != 0) fdo <= fq.pop_front();
         if (wr_en) fq.push_back(wr_data);
         fcnt <= fq.size();
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         bidx = 0;
         stall_prev = 1'b0;
      end else begin
         if (fifo_rd_en) rd_cnt++;
         if (stall_prev) begin
            chk("stall_data_stable", m_data, prev_data);
            chk("stall_last_stable", m_last, prev_last);
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("unexpected_beat", m_data, 32'hFFFF_FFFF);
            else begin
               chk("beat_data", m_data, exp_q.pop_front());
               chk("beat_last", m_last, bidx % BL == BL - 1);
            end
            if (beats == 0) first_cyc = cyc;
            last_cyc = cyc;
            bidx++;
            beats++;
            if (m_last) lasts++;
         end
         stall_prev = m_valid && !m_ready;
         prev_data = m_data;
         prev_last = m_last;
      end
   end

   task automatic run(input vec_t v);
      int c = 0, rd0 = rd_cnt, rs = 0;
      bit done = 0;
      beats = 0;
      lasts = 0;
      for (int g = 0; g < 4000 && !done; g++) begin
         @(posedge clk);
         #1;
         wr_en = c < v.n;
         if (wr_en) begin
            wr_data = 16'(v.base + c);
            exp_q.push_back(wr_data);
         end
         m_ready = v.mode == 0 ? 1'b1 : v.mode == 1 ? !(c >= 6 && c < 11) :
                   v.mode == 2 ? 1'($urandom_range(0, 1)) : (c % 2) == 0;
         if (v.mode == 1 && c == 6) rs = rd_cnt;
         if (v.mode == 1 && c == 11) begin
            chk("stall_reads_le2", (rd_cnt - rs) <= 2, 1);
            chk("stall_occ", dut.occ, 2);
         end
         c++;
         done = c > v.n && exp_q.size() == 0;
      end
      wr_en = 1'b0;
      if (!done) chk("drain_timeout", 0, 1);
      chk("beats", beats, v.n);
      chk("reads", rd_cnt - rd0, v.n);
      chk("lasts", lasts, v.exp_lasts);
      if (v.mode == 0) chk("throughput", last_cyc - first_cyc, v.n - 1);
   endtask

   initial begin
      int rs;
      vecs[0] = '{n: 16,  base: 16'h0001, mode: 0, exp_lasts: 2};
      vecs[1] = '{n: 16,  base: 16'h0100, mode: 1, exp_lasts: 2};
      vecs[2] = '{n: 200, base: 16'h1000, mode: 2, exp_lasts: 25};
      vecs[3] = '{n: 12,  base: 16'h2000, mode: 3, exp_lasts: 1};

      repeat (2) @(negedge clk);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_err", err, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 4; i++) run(vecs[i]);

      m_ready = 1'b1;
      rs = rd_cnt;
      @(posedge clk);
      #1;
      wr_en = 1'b1;
      wr_data = 16'hBEEF;
      exp_q.push_back(16'hBEEF);
      @(posedge clk);
      #1 wr_en = 1'b0;
      @(negedge clk);
      chk("single_empty_k", fifo_empty, 0);
      chk("single_rd_k", fifo_rd_en, 1);
      chk("single_valid_k", m_valid, 0);
      @(negedge clk);
      chk("single_rd_k1", fifo_rd_en, 0);
      chk("single_valid_k1", m_valid, 0);
      @(negedge clk);
      chk("single_valid_k2", m_valid, 1);
      chk("single_data_k2", m_data, 16'hBEEF);
      repeat (3) @(negedge clk);
      chk("single_rd_pulses", rd_cnt - rs, 1);
      chk("single_underflow", fifo_underflow, 0);
      chk("single_err", err, 0);
      chk("single_drained", exp_q.size(), 0);

      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         wr_en = 1'b1;
         wr_data = 16'(16'h5500 + i);
         exp_q.push_back(wr_data);
      end
      @(posedge clk);
      #1 wr_en = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_reset_occ", dut.occ, 2);
      chk("pre_reset_valid", m_valid, 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_valid", m_valid, 0);
      chk("midrst_data", m_data, 0);
      chk("midrst_last", m_last, 0);
      chk("midrst_rd_en", fifo_rd_en, 0);
      chk("midrst_occ", dut.occ, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run('{n: 8, base: 16'h3300, mode: 0, exp_lasts: 1});

      @(posedge clk);
      #1 uf_force = 1'b1;
      @(posedge clk);
      #1 uf_force = 1'b0;
      @(negedge clk);
      chk("uf_err_set", err, 1);
      repeat (3) @(negedge clk);
      chk("uf_err_sticky", err, 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("uf_err_reset", err, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
